// File: rtl/matrix_output_mode.sv
// Prints one stored matrix over UART: takes a slot digit, queries the matrix manager for shape
// and base address, then streams the elements row-major as unsigned decimal ASCII text.
module matrix_output_mode #(
  parameter int unsigned ELEMENT_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH    = 9,
  parameter int unsigned QUERY_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode_active,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic                     query_req,
  output logic [3:0]               query_slot,
  input  logic                     query_valid,
  input  logic                     query_exists,
  input  logic [3:0]               query_m,
  input  logic [3:0]               query_n,
  input  logic [ADDR_WIDTH-1:0]    query_addr,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
  input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
  output logic [3:0]               error_code,
  output logic [3:0]               sub_state
);

  localparam int unsigned QCW = $clog2(QUERY_TIMEOUT + 1);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StWaitSlot = 4'd1,
    StQuery    = 4'd2,
    StHeader   = 4'd3,
    StFetch    = 4'd4,
    StConvert  = 4'd5,
    StSendNum  = 4'd6,
    StSep      = 4'd7,
    StTrailer  = 4'd8,
    StDone     = 4'd9,
    StError    = 4'd10
  } state_e;

  state_e                   state_q, state_d;
  state_e                   ret_q, ret_d;
  logic [2:0]               hdr_q, hdr_d;
  logic [1:0]               phase_q, phase_d;
  logic [1:0]               fetch_q, fetch_d;
  logic [QCW-1:0]           qcnt_q, qcnt_d;
  logic [3:0]               m_q, m_d;
  logic [3:0]               n_q, n_d;
  logic [ADDR_WIDTH-1:0]    base_q, base_d;
  logic [7:0]               row_q, row_d;
  logic [7:0]               col_q, col_d;
  logic [7:0]               idx_q, idx_d;
  logic [ELEMENT_WIDTH-1:0] val_q, val_d;
  logic [3:0]               hund_q, hund_d;
  logic [3:0]               tens_q, tens_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic                     tx_start_q, tx_start_d;
  logic                     query_req_q, query_req_d;
  logic [3:0]               query_slot_q, query_slot_d;
  logic [3:0]               error_q, error_d;
  logic                     can_send;

  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  // A new byte may go out only when the UART is idle and no request is already in flight.
  assign can_send = !tx_busy && !tx_start_q;

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    hdr_d        = hdr_q;
    phase_d      = phase_q;
    fetch_d      = fetch_q;
    qcnt_d       = qcnt_q;
    m_d          = m_q;
    n_d          = n_q;
    base_d       = base_q;
    row_d        = row_q;
    col_d        = col_q;
    idx_d        = idx_q;
    val_d        = val_q;
    hund_d       = hund_q;
    tens_d       = tens_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    query_req_d  = query_req_q;
    query_slot_d = query_slot_q;
    error_d      = error_q;

    unique case (state_q)
      StIdle: begin
        error_d     = 4'd0;
        row_d       = 8'd0;
        col_d       = 8'd0;
        idx_d       = 8'd0;
        qcnt_d      = '0;
        query_req_d = 1'b0;
        phase_d     = 2'd0;
        hdr_d       = 3'd0;
        state_d     = StWaitSlot;
      end

      StWaitSlot: begin
        if (rx_done && (rx_data >= 8'h30) && (rx_data <= 8'h39)) begin
          query_slot_d = rx_data[3:0];
          query_req_d  = 1'b1;
          qcnt_d       = '0;
          state_d      = StQuery;
        end
      end

      StQuery: begin
        // A response arriving on the timeout cycle still counts.
        if (query_valid) begin
          query_req_d = 1'b0;
          if (query_exists) begin
            m_d     = query_m;
            n_d     = query_n;
            base_d  = query_addr;
            row_d   = 8'd0;
            col_d   = 8'd0;
            idx_d   = 8'd0;
            hdr_d   = 3'd0;
            state_d = StHeader;
          end else begin
            error_d = 4'd4;
            phase_d = 2'd0;
            state_d = StError;
          end
        end else if (qcnt_q == QCW'(QUERY_TIMEOUT - 1)) begin
          query_req_d = 1'b0;
          error_d     = 4'd5;
          phase_d     = 2'd0;
          state_d     = StError;
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end

      // Numbers in the header go through CONVERT/SEND_NUM and come back here via ret_q.
      StHeader: begin
        case (hdr_q)
          3'd0: begin
            val_d   = ELEMENT_WIDTH'(m_q);
            hund_d  = 4'd0;
            tens_d  = 4'd0;
            ret_d   = StHeader;
            hdr_d   = 3'd1;
            state_d = StConvert;
          end
          3'd1: begin
            if (can_send) begin
              tx_start_d = 1'b1;
              tx_data_d  = 8'h2a;
              hdr_d      = 3'd2;
            end
          end
          3'd2: begin
            val_d   = ELEMENT_WIDTH'(n_q);
            hund_d  = 4'd0;
            tens_d  = 4'd0;
            ret_d   = StHeader;
            hdr_d   = 3'd3;
            state_d = StConvert;
          end
          3'd3: begin
            if (can_send) begin
              tx_start_d = 1'b1;
              tx_data_d  = 8'h0d;
              hdr_d      = 3'd4;
            end
          end
          default: begin
            if (can_send) begin
              tx_start_d = 1'b1;
              tx_data_d  = 8'h0a;
              fetch_d    = 2'd0;
              state_d    = StFetch;
            end
          end
        endcase
      end

      // Address is stable from entry; the registered BRAM output is ready two cycles later.
      StFetch: begin
        if (fetch_q == 2'd2) begin
          val_d   = mem_rd_data;
          hund_d  = 4'd0;
          tens_d  = 4'd0;
          ret_d   = StSep;
          state_d = StConvert;
        end else begin
          fetch_d = fetch_q + 2'd1;
        end
      end

      StConvert: begin
        if (val_q >= ELEMENT_WIDTH'(100)) begin
          val_d  = val_q - ELEMENT_WIDTH'(100);
          hund_d = hund_q + 4'd1;
        end else if (val_q >= ELEMENT_WIDTH'(10)) begin
          val_d  = val_q - ELEMENT_WIDTH'(10);
          tens_d = tens_q + 4'd1;
        end else begin
          phase_d = 2'd0;
          state_d = StSendNum;
        end
      end

      StSendNum: begin
        case (phase_q)
          2'd0: begin
            if (hund_q == 4'd0) begin
              phase_d = 2'd1;
            end else if (can_send) begin
              tx_start_d = 1'b1;
              tx_data_d  = to_ascii(hund_q);
              phase_d    = 2'd1;
            end
          end
          2'd1: begin
            if ((hund_q == 4'd0) && (tens_q == 4'd0)) begin
              phase_d = 2'd2;
            end else if (can_send) begin
              tx_start_d = 1'b1;
              tx_data_d  = to_ascii(tens_q);
              phase_d    = 2'd2;
            end
          end
          default: begin
            if (can_send) begin
              tx_start_d = 1'b1;
              tx_data_d  = to_ascii(val_q[3:0]);
              phase_d    = 2'd0;
              state_d    = ret_q;
            end
          end
        endcase
      end

      StSep: begin
        if (phase_q == 2'd0) begin
          if ((col_q + 8'd1) < {4'h0, n_q}) begin
            if (can_send) begin
              tx_start_d = 1'b1;
              tx_data_d  = 8'h20;
              col_d      = col_q + 8'd1;
              idx_d      = idx_q + 8'd1;
              fetch_d    = 2'd0;
              state_d    = StFetch;
            end
          end else if ((row_q + 8'd1) < {4'h0, m_q}) begin
            if (can_send) begin
              tx_start_d = 1'b1;
              tx_data_d  = 8'h0d;
              phase_d    = 2'd1;
            end
          end else begin
            phase_d = 2'd0;
            state_d = StTrailer;
          end
        end else if (can_send) begin
          tx_start_d = 1'b1;
          tx_data_d  = 8'h0a;
          row_d      = row_q + 8'd1;
          col_d      = 8'd0;
          idx_d      = idx_q + 8'd1;
          fetch_d    = 2'd0;
          phase_d    = 2'd0;
          state_d    = StFetch;
        end
      end

      StTrailer: begin
        if (can_send) begin
          tx_start_d = 1'b1;
          if (phase_q == 2'd0) begin
            tx_data_d = 8'h0d;
            phase_d   = 2'd1;
          end else begin
            tx_data_d = 8'h0a;
            phase_d   = 2'd0;
            state_d   = StDone;
          end
        end
      end

      StDone: begin
        state_d = StWaitSlot;
      end

      // The wake-up byte is only honoured once the 'E' has gone out.
      StError: begin
        if (phase_q == 2'd0) begin
          if (can_send) begin
            tx_start_d = 1'b1;
            tx_data_d  = 8'h45;
            phase_d    = 2'd1;
          end
        end else if (rx_done) begin
          error_d = 4'd0;
          phase_d = 2'd0;
          state_d = StWaitSlot;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (!mode_active) begin
      state_d     = StIdle;
      query_req_d = 1'b0;
      tx_start_d  = 1'b0;
      error_d     = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ret_q        <= StSep;
      hdr_q        <= 3'd0;
      phase_q      <= 2'd0;
      fetch_q      <= 2'd0;
      qcnt_q       <= '0;
      m_q          <= 4'd0;
      n_q          <= 4'd0;
      base_q       <= '0;
      row_q        <= 8'd0;
      col_q        <= 8'd0;
      idx_q        <= 8'd0;
      val_q        <= '0;
      hund_q       <= 4'd0;
      tens_q       <= 4'd0;
      tx_data_q    <= 8'd0;
      tx_start_q   <= 1'b0;
      query_req_q  <= 1'b0;
      query_slot_q <= 4'd0;
      error_q      <= 4'd0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      hdr_q        <= hdr_d;
      phase_q      <= phase_d;
      fetch_q      <= fetch_d;
      qcnt_q       <= qcnt_d;
      m_q          <= m_d;
      n_q          <= n_d;
      base_q       <= base_d;
      row_q        <= row_d;
      col_q        <= col_d;
      idx_q        <= idx_d;
      val_q        <= val_d;
      hund_q       <= hund_d;
      tens_q       <= tens_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      query_req_q  <= query_req_d;
      query_slot_q <= query_slot_d;
      error_q      <= error_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign query_req   = query_req_q;
  assign query_slot  = query_slot_q;
  assign error_code  = error_q;
  assign sub_state   = state_q;
  assign mem_rd_en   = (state_q >= StHeader) && (state_q <= StTrailer);
  // Running element index replaces a row*n+col multiply.
  assign mem_rd_addr = base_q + ADDR_WIDTH'(idx_q);

endmodule

// File: tb/tb_matrix_output_mode.sv
// Directed bench for matrix_output_mode: UART, matrix manager and BRAM are modelled here and
// the transmitted byte stream is compared against hand-written text.
module tb_matrix_output_mode;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_active;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic       query_req;
  logic [3:0] query_slot;
  logic       query_valid;
  logic       query_exists;
  logic [3:0] query_m;
  logic [3:0] query_n;
  logic [8:0] query_addr;
  logic       mem_rd_en;
  logic [8:0] mem_rd_addr;
  logic [7:0] mem_rd_data;
  logic [3:0] error_code;
  logic [3:0] sub_state;

  matrix_output_mode #(
    .ELEMENT_WIDTH(8),
    .ADDR_WIDTH   (9),
    .QUERY_TIMEOUT(255)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode_active (mode_active),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .query_req   (query_req),
    .query_slot  (query_slot),
    .query_valid (query_valid),
    .query_exists(query_exists),
    .query_m     (query_m),
    .query_n     (query_n),
    .query_addr  (query_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .error_code  (error_code),
    .sub_state   (sub_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // BRAM with one registered read stage.
  logic [7:0] mem [512];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  // UART: records each requested byte and stays busy for busy_len cycles.
  int          busy_len   = 3;
  int          busy_cnt   = 0;
  int          n_viol     = 0;
  logic        prev_start = 1'b0;
  byte unsigned got[$];
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      if (tx_busy || prev_start) n_viol++;
      got.push_back(tx_data);
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    prev_start = tx_start;
    tx_busy = (busy_cnt > 0);
  end

  typedef struct packed {
    logic [7:0]  val;
    logic [3:0]  slot;
    logic [8:0]  base;
    logic [7:0]  delay;
    logic [1:0]  ndig;
    logic [23:0] txt;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_stream(input string name, input string exp);
    string s = "";
    int    bad = -1;
    foreach (got[i]) s = {s, $sformatf("%c", got[i])};
    n_checks++;
    if (s != exp) begin
      for (int i = 0; i < s.len() && i < exp.len(); i++) begin
        if (bad < 0 && s[i] != exp[i]) bad = i;
      end
      n_fail++;
      $display("FAIL %s: got %0d bytes, required %0d bytes, first difference at %0d",
               name, s.len(), exp.len(), bad);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic run_query(input logic ex, input logic [3:0] m, input logic [3:0] n,
                           input logic [8:0] a, input int delay, input logic [3:0] slot);
    int c = 0;
    while (query_req !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("query_req_seen", {31'd0, query_req}, 32'd1);
    check("query_slot", {28'd0, query_slot}, {28'd0, slot});
    repeat (delay) @(negedge clk);
    query_exists = ex;
    query_m      = m;
    query_n      = n;
    query_addr   = a;
    query_valid  = 1'b1;
    @(negedge clk);
    query_valid  = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input int bound, input string name);
    int c = 0;
    while (sub_state !== s && c < bound) begin
      @(negedge clk);
      c++;
    end
    check(name, {28'd0, sub_state}, {28'd0, s});
  endtask

  task automatic wait_bytes(input int nb, input int bound);
    int c = 0;
    while (got.size() < nb && c < bound) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic drain();
    int c = 0;
    while ((busy_cnt > 0 || tx_start === 1'b1) && c < 5000) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] junk [5];
    string      e;

    tbl[0] = '{8'd0,   4'd1, 9'h000, 8'd0,   2'd1, {16'h0, "0"}};
    tbl[1] = '{8'd9,   4'd3, 9'h001, 8'd1,   2'd1, {16'h0, "9"}};
    tbl[2] = '{8'd10,  4'd4, 9'h0ff, 8'd2,   2'd2, {8'h0, "10"}};
    tbl[3] = '{8'd99,  4'd5, 9'h100, 8'd3,   2'd2, {8'h0, "99"}};
    tbl[4] = '{8'd100, 4'd6, 9'h1ff, 8'd0,   2'd3, "100"};
    tbl[5] = '{8'd101, 4'd8, 9'h055, 8'd7,   2'd3, "101"};
    tbl[6] = '{8'd110, 4'd0, 9'h0aa, 8'd1,   2'd3, "110"};
    tbl[7] = '{8'd199, 4'd1, 9'h123, 8'd254, 2'd3, "199"};  // response on the timeout cycle
    tbl[8] = '{8'd200, 4'd9, 9'h1f0, 8'd0,   2'd3, "200"};
    tbl[9] = '{8'd255, 4'd2, 9'h002, 8'd253, 2'd3, "255"};

    junk[0] = 8'h61; junk[1] = 8'h20; junk[2] = 8'h0d; junk[3] = 8'h2f; junk[4] = 8'h3a;

    for (int i = 0; i < 512; i++) mem[i] = 8'd0;
    rst = 1'b1; mode_active = 1'b1; rx_data = 8'd0; rx_done = 1'b0;
    query_valid = 1'b0; query_exists = 1'b0; query_m = 4'd0; query_n = 4'd0; query_addr = 9'd0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_query_req", {31'd0, query_req}, 32'd0);
    check("rst_query_slot", {28'd0, query_slot}, 32'd0);
    check("rst_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst_mem_rd_addr", {23'd0, mem_rd_addr}, 32'd0);
    check("rst_error_code", {28'd0, error_code}, 32'd0);
    check("rst_sub_state", {28'd0, sub_state}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_to_wait", {28'd0, sub_state}, 32'd1);

    // Non-digit bytes are ignored in WAIT_SLOT
    for (int i = 0; i < 5; i++) begin
      send_rx(junk[i]);
      check("junk_state", {28'd0, sub_state}, 32'd1);
      check("junk_query_req", {31'd0, query_req}, 32'd0);
    end

    // '9' with no answer: query_req high for exactly 255 cycles, then timeout error
    send_rx(8'h39);
    check("slot9_query_req", {31'd0, query_req}, 32'd1);
    check("slot9_query_slot", {28'd0, query_slot}, 32'd9);
    begin
      int c = 0;
      while (query_req === 1'b1 && c < 1000) begin
        c++;
        @(negedge clk);
      end
      check("timeout_req_cycles", c, 32'd255);
    end
    check("timeout_error", {28'd0, error_code}, 32'd5);
    check("timeout_state", {28'd0, sub_state}, 32'd10);
    wait_bytes(1, 100);
    drain();
    check_stream("timeout_E", "E");
    check("timeout_error_held", {28'd0, error_code}, 32'd5);
    send_rx(8'h7a);
    check("timeout_clear_err", {28'd0, error_code}, 32'd0);
    check("timeout_clear_state", {28'd0, sub_state}, 32'd1);
    got.delete();

    // Slot 2, 2x3 matrix
    mem[9'h040] = 8'd0;   mem[9'h041] = 8'd5; mem[9'h042] = 8'd10;
    mem[9'h043] = 8'd255; mem[9'h044] = 8'd7; mem[9'h045] = 8'd100;
    send_rx(8'h32);
    run_query(1'b1, 4'd2, 4'd3, 9'h040, 5, 4'd2);
    check("main_header_state", {28'd0, sub_state}, 32'd3);
    check("main_rd_en", {31'd0, mem_rd_en}, 32'd1);
    wait_state(4'd9, 3000, "main_done");
    @(negedge clk);
    check("main_back_wait", {28'd0, sub_state}, 32'd1);
    check("main_error", {28'd0, error_code}, 32'd0);
    drain();
    check_stream("main_stream", "2*3\r\n0 5 10\r\n255 7 100\r\n");
    got.delete();

    // Slot 7 empty
    send_rx(8'h37);
    run_query(1'b0, 4'd0, 4'd0, 9'h000, 3, 4'd7);
    check("empty_error", {28'd0, error_code}, 32'd4);
    wait_bytes(1, 100);
    drain();
    check_stream("empty_E", "E");
    send_rx(8'h78);
    check("empty_clear_err", {28'd0, error_code}, 32'd0);
    check("empty_clear_state", {28'd0, sub_state}, 32'd1);
    repeat (5) @(negedge clk);
    check("empty_no_query", {31'd0, query_req}, 32'd0);
    got.delete();

    // 1x1 matrices across the digit-printing boundaries
    for (int i = 0; i < 10; i++) begin
      mem[tbl[i].base] = tbl[i].val;
      send_rx(8'h30 + {4'h0, tbl[i].slot});
      run_query(1'b1, 4'd1, 4'd1, tbl[i].base, int'(tbl[i].delay), tbl[i].slot);
      wait_state(4'd9, 2000, "vec_done");
      @(negedge clk);
      check("vec_back_wait", {28'd0, sub_state}, 32'd1);
      drain();
      e = "1*1\r\n";
      for (int k = int'(tbl[i].ndig) - 1; k >= 0; k--) e = {e, $sformatf("%c", tbl[i].txt[8*k +: 8])};
      e = {e, "\r\n"};
      check_stream($sformatf("vec_stream_%0d", tbl[i].val), e);
      got.delete();
    end

    // Slow UART: 50 busy cycles per byte
    busy_len = 50;
    mem[9'h1ab] = 8'd0;
    send_rx(8'h34);
    run_query(1'b1, 4'd1, 4'd1, 9'h1ab, 0, 4'd4);
    wait_state(4'd9, 5000, "slow_done");
    drain();
    check_stream("slow_stream", "1*1\r\n0\r\n");
    got.delete();
    busy_len = 3;

    // mode_active dropped during row 1 of a 3x3 matrix
    for (int k = 0; k < 9; k++) mem[9'h100 + k] = 8'(k + 1);
    send_rx(8'h33);
    run_query(1'b1, 4'd3, 4'd3, 9'h100, 2, 4'd3);
    wait_bytes(13, 3000);
    check("drop_row1_reached", got.size(), 32'd13);
    mode_active = 1'b0;
    @(negedge clk);
    check("drop_state", {28'd0, sub_state}, 32'd0);
    check("drop_tx_start", {31'd0, tx_start}, 32'd0);
    check("drop_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("drop_query_req", {31'd0, query_req}, 32'd0);
    mode_active = 1'b1;
    drain();
    repeat (3) @(negedge clk);
    check("resume_state", {28'd0, sub_state}, 32'd1);
    send_rx(8'h71);
    repeat (3) @(negedge clk);
    check("resume_ignore_state", {28'd0, sub_state}, 32'd1);
    check("resume_no_query", {31'd0, query_req}, 32'd0);

    check("tx_protocol", n_viol, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
